// File: rtl/sad_block_accum.sv
// rtl/sad_block_accum.sv - pipelined sum-of-absolute-differences block accumulator
//
// Streams LANES unsigned pixel pairs per beat, sums |a-b| over BLK_BEATS beats
// into one block SAD, and keeps the smallest block SAD seen since clear/reset.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   clear      in   synchronous flush, active high, overrides everything
//   a, b       in   LANES*PIX_W packed pixels, lane i at [i*PIX_W +: PIX_W]
//   in_valid   in   beat present on a/b
//   in_ready   out  beat accepted when in_valid && in_ready
//   sad_out    out  completed block SAD
//   blk_idx    out  index of the block on sad_out
//   out_valid  out  sad_out/blk_idx valid
//   out_ready  in   consumer takes the result when out_valid && out_ready
//   min_sad    out  smallest block SAD since clear/reset
//   min_idx    out  block index of min_sad
module sad_block_accum #(
    parameter int LANES     = 4,
    parameter int PIX_W     = 8,
    parameter int BLK_BEATS = 16,
    parameter int IDX_W     = 8,
    localparam int SUM_W    = PIX_W + $clog2(LANES),
    localparam int ACC_W    = SUM_W + $clog2(BLK_BEATS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [LANES*PIX_W-1:0] a,
    input  logic [LANES*PIX_W-1:0] b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ACC_W-1:0]       sad_out,
    output logic [IDX_W-1:0]       blk_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       min_sad,
    output logic [IDX_W-1:0]       min_idx
);

    localparam int BC_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BLK_BEATS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    ostate_t state_q, state_d;

    logic                   rdy_q;
    logic                   stall;
    logic                   accept;
    logic                   produce;

    // Beat capture stage: raw pixels plus the last-beat tag.
    logic                   s0_valid;
    logic                   s0_last;
    logic [LANES*PIX_W-1:0] s0_a;
    logic [LANES*PIX_W-1:0] s0_b;
    logic [BC_W-1:0]        beat_cnt;

    // S1: per-lane absolute differences.
    logic                   s1_valid;
    logic                   s1_last;
    logic [LANES*PIX_W-1:0] s1_abs;
    logic [LANES*PIX_W-1:0] abs_d;
    logic [PIX_W:0]         diff_d [LANES];

    // S2: lane sum.
    logic                   s2_valid;
    logic                   s2_last;
    logic [SUM_W-1:0]       s2_sum;
    logic [SUM_W-1:0]       lane_sum;

    // S3: block accumulator and result bookkeeping.
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_total;
    logic [IDX_W-1:0]       blk_cnt;
    logic                   first_blk;

    assign out_valid = (state_q == FULL);
    assign stall     = out_valid && !out_ready;
    // rdy_q keeps in_ready low while reset is held and lets it rise on the
    // first edge after release.
    assign in_ready  = rdy_q && !stall && !clear;
    assign accept    = in_valid && in_ready;
    assign acc_total = acc + ACC_W'(s2_sum);
    assign produce   = s2_valid && s2_last && !stall;

    // Differences are taken one bit wider so they never wrap; the magnitude
    // always fits back into PIX_W bits, so negating the low bits is exact.
    always_comb begin
        abs_d = '0;
        for (int i = 0; i < LANES; i++) begin
            diff_d[i] = {1'b0, s0_a[i*PIX_W +: PIX_W]} - {1'b0, s0_b[i*PIX_W +: PIX_W]};
            if (diff_d[i][PIX_W]) begin
                abs_d[i*PIX_W +: PIX_W] = ~diff_d[i][PIX_W-1:0] + PIX_W'(1);
            end else begin
                abs_d[i*PIX_W +: PIX_W] = diff_d[i][PIX_W-1:0];
            end
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(s1_abs[i*PIX_W +: PIX_W]);
        end
    end

    // Output FSM: EMPTY until a block completes, FULL while a result waits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (produce) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = produce ? FULL : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (clear) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid  <= 1'b0;
            s0_last   <= 1'b0;
            s0_a      <= '0;
            s0_b      <= '0;
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_abs    <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_sum    <= '0;
            acc       <= '0;
            blk_cnt   <= '0;
            sad_out   <= '0;
            blk_idx   <= '0;
            min_sad   <= '1;
            min_idx   <= '0;
            first_blk <= 1'b1;
        end else if (clear) begin
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            beat_cnt  <= '0;
            acc       <= '0;
            blk_cnt   <= '0;
            sad_out   <= '0;
            blk_idx   <= '0;
            min_sad   <= '1;
            min_idx   <= '0;
            first_blk <= 1'b1;
        end else if (!stall) begin
            s0_valid <= accept;
            if (accept) begin
                s0_a    <= a;
                s0_b    <= b;
                s0_last <= (beat_cnt == LAST_BEAT);
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + BC_W'(1);
                end
            end

            s1_valid <= s0_valid;
            s1_last  <= s0_last;
            s1_abs   <= abs_d;

            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_sum   <= lane_sum;

            if (s2_valid) begin
                if (s2_last) begin
                    sad_out   <= acc_total;
                    blk_idx   <= blk_cnt;
                    blk_cnt   <= blk_cnt + IDX_W'(1);
                    acc       <= '0;
                    first_blk <= 1'b0;
                    // Strict less-than: a tie keeps the earlier block.
                    if (first_blk || (acc_total < min_sad)) begin
                        min_sad <= acc_total;
                        min_idx <= blk_cnt;
                    end
                end else begin
                    acc <= acc_total;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_block_accum.sv
// tb/tb_sad_block_accum.sv - self-checking bench for sad_block_accum
module tb_sad_block_accum;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        clr1 = 1'b0, iv1 = 1'b0, or1 = 1'b1;
    logic [31:0] a1 = '0, b1 = '0;
    logic        ir1, ov1;
    logic [13:0] sad1, mn1;
    logic [7:0]  idx1, mni1;

    // LANES=8, PIX_W=10, BLK_BEATS=5 instance
    logic        clr2 = 1'b0, iv2 = 1'b0, or2 = 1'b1;
    logic [79:0] a2 = '0, b2 = '0;
    logic        ir2, ov2;
    logic [15:0] sad2, mn2;
    logic [7:0]  idx2, mni2;

    sad_block_accum dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clr1), .a(a1), .b(b1),
        .in_valid(iv1), .in_ready(ir1), .sad_out(sad1), .blk_idx(idx1),
        .out_valid(ov1), .out_ready(or1), .min_sad(mn1), .min_idx(mni1)
    );

    sad_block_accum #(.LANES(8), .PIX_W(10), .BLK_BEATS(5), .IDX_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clr2), .a(a2), .b(b2),
        .in_valid(iv2), .in_ready(ir2), .sad_out(sad2), .blk_idx(idx2),
        .out_valid(ov2), .out_ready(or2), .min_sad(mn2), .min_idx(mni2)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint sad;
        int     idx;
        longint mn;
        int     mni;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    longint m_part [2];
    int     m_beat [2];
    int     m_idx  [2];
    longint m_min  [2];
    int     m_mni  [2];
    bit     m_first[2];

    function automatic longint beat_sad(input logic [79:0] av, input logic [79:0] bv,
                                        input int lanes, input int pw);
        longint s = 0;
        for (int i = 0; i < lanes; i++) begin
            logic [79:0] sa, sb;
            int xa, xb;
            sa = av >> (i * pw);
            sb = bv >> (i * pw);
            xa = int'(sa[15:0]) & ((1 << pw) - 1);
            xb = int'(sb[15:0]) & ((1 << pw) - 1);
            s += (xa > xb) ? (xa - xb) : (xb - xa);
        end
        return s;
    endfunction

    task automatic model_reset(input int d, input int accw);
        m_part[d]  = 0;
        m_beat[d]  = 0;
        m_idx[d]   = 0;
        m_min[d]   = (longint'(1) << accw) - 1;
        m_mni[d]   = 0;
        m_first[d] = 1'b1;
        if (d == 0) q0.delete();
        else q1.delete();
    endtask

    task automatic model_cycle(input int d, input bit rstn, input bit clr,
                               input bit ov, input bit ordy, input bit iv, input bit ir,
                               input longint sad, input int idx, input longint mn, input int mni,
                               input logic [79:0] av, input logic [79:0] bv,
                               input int lanes, input int pw, input int beats, input int accw);
        exp_t e;
        if (!rstn) begin
            model_reset(d, accw);
        end else if (clr) begin
            chk("clear_blocks_input", ir, 0);
            model_reset(d, accw);
        end else begin
            if (ov && !ordy) chk("stall_in_ready", ir, 0);
            if (ov && ordy) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("sad_out", sad, e.sad);
                    chk("blk_idx", idx, e.idx);
                    chk("min_sad", mn, e.mn);
                    chk("min_idx", mni, e.mni);
                end
            end
            if (iv && ir) begin
                m_part[d] += beat_sad(av, bv, lanes, pw);
                m_beat[d]++;
                if (m_beat[d] == beats) begin
                    if (m_first[d] || m_part[d] < m_min[d]) begin
                        m_min[d] = m_part[d];
                        m_mni[d] = m_idx[d];
                    end
                    m_first[d] = 1'b0;
                    e.sad = m_part[d];
                    e.idx = m_idx[d];
                    e.mn  = m_min[d];
                    e.mni = m_mni[d];
                    if (d == 0) q0.push_back(e);
                    else q1.push_back(e);
                    m_idx[d]  = (m_idx[d] + 1) % 256;
                    m_part[d] = 0;
                    m_beat[d] = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0, rst_n, clr1, ov1, or1, iv1, ir1, sad1, idx1, mn1, mni1,
                    {48'b0, a1}, {48'b0, b1}, 4, 8, 16, 14);
        model_cycle(1, rst_n, clr2, ov2, or2, iv2, ir2, sad2, idx2, mn2, mni2,
                    a2, b2, 8, 10, 5, 16);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send1(input logic [31:0] av, input logic [31:0] bv);
        bit got;
        int n = 0;
        iv1 = 1'b1;
        a1 = av;
        b1 = bv;
        do begin
            @(negedge clk);
            got = ir1;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 200);
        if (!got) chk("send_timeout", 0, 1);
        iv1 = 1'b0;
    endtask

    task automatic pulse_clear1();
        clr1 = 1'b1;
        @(posedge clk);
        #1;
        clr1 = 1'b0;
    endtask

    task automatic wait_ov1();
        int n = 0;
        while (!ov1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ov1) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        or1 = 1'b1;
        or2 = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0 || ov1 || ov2) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    initial begin
        int n;
        int sent;
        int cyc;
        logic [79:0] ra;

        repeat (2) @(posedge clk);
        #3;
        chk("reset_sad_out", sad1, 0);
        chk("reset_out_valid", ov1, 0);
        chk("reset_in_ready", ir1, 0);
        chk("reset_min_sad", mn1, 14'h3FFF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: 16 beats of full-scale difference, 3-cycle latency.
        for (int i = 0; i < 16; i++) send1(32'hFF00_FF00, 32'h00FF_00FF);
        n = 0;
        while (!ov1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t1_latency", n, 3);
        chk("t1_sad", sad1, 16320);
        chk("t1_idx", idx1, 0);
        drain();

        // Test 2: per-beat SAD 10, 4, 4 -> tie keeps block 1.
        pulse_clear1();
        for (int i = 0; i < 16; i++) send1(32'd10, 32'd0);
        for (int i = 0; i < 16; i++) send1(32'd0, 32'd4);
        for (int i = 0; i < 16; i++) send1(32'h0000_0400, 32'h0000_0000);
        drain();
        chk("t2_min_sad", mn1, 64);
        chk("t2_min_idx", mni1, 1);

        // Test 3: consumer stalls while the next block streams.
        fork
            begin
                for (int i = 0; i < 32; i++) send1($urandom, $urandom);
            end
            begin
                or1 = 1'b0;
                repeat (30) @(posedge clk);
                #1;
                chk("t3_stalled_valid", ov1, 1);
                chk("t3_stalled_ready", ir1, 0);
                or1 = 1'b1;
            end
        join
        drain();

        // Test 4: clear discards a partial block.
        for (int i = 0; i < 7; i++) send1($urandom, $urandom);
        pulse_clear1();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] r;
            r = $urandom;
            send1(r, r);
        end
        wait_ov1();
        chk("t4_sad", sad1, 0);
        chk("t4_idx", idx1, 0);
        drain();
        chk("t4_min_sad", mn1, 0);
        chk("t4_min_idx", mni1, 0);

        // Test 5: async reset mid-block with a held result.
        or1 = 1'b0;
        for (int i = 0; i < 19; i++) send1(32'hFFFF_FFFF, 32'h0000_0000);
        chk("t5_pre_valid", ov1, 1);
        iv1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sad", sad1, 0);
        chk("t5_rst_idx", idx1, 0);
        chk("t5_rst_valid", ov1, 0);
        chk("t5_rst_ready", ir1, 0);
        chk("t5_rst_min_sad", mn1, 14'h3FFF);
        chk("t5_rst_min_idx", mni1, 0);
        @(posedge clk);
        #1;
        chk("t5_rst_hold_ready", ir1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        iv1 = 1'b0;
        or1 = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_ready_after", ir1, 1);

        // Test 6: 1000 random blocks with random gaps on the wide instance.
        sent = 0;
        cyc = 0;
        while (sent < 5000 && cyc < 60000) begin
            @(negedge clk);
            if (iv2 && ir2) sent++;
            @(posedge clk);
            #1;
            cyc++;
            ra = {$urandom, $urandom, $urandom};
            a2 = ra;
            b2 = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom, $urandom};
            iv2 = (sent < 5000) && ($urandom_range(0, 3) != 0);
            or2 = ($urandom_range(0, 2) != 0);
        end
        iv2 = 1'b0;
        chk("t6_beats_sent", sent, 5000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
